// File: rtl/arith_pkg.sv
// Shared definitions for the nibble-serial arithmetic blocks.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents:
//   state_t   - control FSM states of the serial subtractor
//   NIBBLE_W  - width of the lookahead slice reused every cycle
//   idx_width - width of a counter that indexes a given number of nibbles
package arith_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-nibble datapath still needs a 1-bit index so the counter
    // declaration never collapses to zero width.
    function automatic int idx_width(input int nibbles);
        if (nibbles <= 1) begin
            return 1;
        end
        return $clog2(nibbles);
    endfunction

endpackage

// File: rtl/cla_slice_4bit.sv
// 4-bit carry-lookahead adder slice: s = x + y + cin.
// Latency: purely combinational.
// Backpressure: none (no state, no handshake).
//
// Ports:
//   x, y  - 4-bit addends
//   cin   - carry in
//   s     - 4-bit sum
//   cout  - carry out of bit 3
module cla_slice_4bit
    import arith_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic                c1;
    logic                c2;
    logic                c3;
    logic                c4;

    assign g = x & y;
    assign p = x ^ y;

    // Every carry is a flat sum-of-products of g, p and cin so no carry
    // depends on the previous one.
    assign c1 = g[0]
              | (p[0] & cin);
    assign c2 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
    assign c3 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
    assign c4 = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ {c3, c2, c1, cin};
    assign cout = c4;

endmodule

// File: rtl/cla_subtractor_serial.sv
// Nibble-serial WIDTH-bit subtractor: diff = a - b - bin, one CLA nibble per clock, LSB first.
// Latency: out_valid rises NIBBLES edges after the accept edge; one op per NIBBLES+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (low during reset).
//
// Ports:
//   clk, rst             - rising-edge clock, synchronous active-high reset
//   in_valid, in_ready   - operand handshake; a, b, bin sampled on the accept edge only
//   a, b, bin            - minuend, subtrahend, borrow in
//   out_valid, out_ready - result handshake
//   diff, bout, zero     - a - b - bin mod 2^WIDTH, unsigned borrow out, diff == 0
//
// WIDTH must be a multiple of 4 and at least 4.
module cla_subtractor_serial
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int                NIBBLES  = WIDTH / NIBBLE_W;
    localparam int                IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              state;
    state_t              state_nxt;

    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    diff_q;
    logic                bout_q;
    logic                zero_q;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] sum_nib;
    logic                slice_cout;
    logic [WIDTH-1:0]    diff_upd;
    logic                last_nib;

    // ------------------------------------------------------------------
    // Operand mux into the shared slice, and the result word with the
    // current nibble merged in. The merged word lets the zero flag see
    // the final nibble on the same edge it is written.
    // ------------------------------------------------------------------
    always_comb begin
        a_nib    = '0;
        b_nib    = '0;
        diff_upd = diff_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
                diff_upd[i*NIBBLE_W +: NIBBLE_W] = sum_nib;
            end
        end
    end

    // Subtraction as a + ~b + ~bin: the inverted borrow rides in as the
    // initial carry, and each slice carry-out is the inverted borrow into
    // the next nibble.
    cla_slice_4bit u_slice (
        .x    (a_nib),
        .y    (~b_nib),
        .cin  (carry),
        .s    (sum_nib),
        .cout (slice_cout)
    );

    assign last_nib = (idx == LAST_IDX);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                // Held low during reset so nothing is accepted on a reset edge.
                in_ready = ~rst;
                if (in_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_nib) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        carry  <= ~bin;
                        idx    <= '0;
                        diff_q <= '0;
                    end
                end
                CALC: begin
                    diff_q <= diff_upd;
                    carry  <= slice_cout;
                    if (last_nib) begin
                        idx    <= '0;
                        bout_q <= ~slice_cout;
                        zero_q <= (diff_upd == '0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    // DONE: result registers hold until the consumer takes them.
                end
            endcase
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule
